bp_table_scheduler: RTL
=======================

Name: bp_table_scheduler

Overview:
- Owns the single-port pattern-history table (saturating counters) behind the history predictors.
- Arbitrates each cycle between fetch-stage lookups and read-modify-write updates from resolved branches.
- Updates are buffered in a small FIFO.
- Sequences whole-table clears after reset or on request.

Parameters:
INDEX_WIDTH, 6, table index width; depth = 2**INDEX_WIDTH
COUNTER_WIDTH, 2, saturating counter width
COUNTER_INIT, 0, value written to every entry during a clear
FIFO_ADDR_WIDTH, 2, update FIFO depth = 2**FIFO_ADDR_WIDTH
STARVE_LIMIT, 4, consecutive lookup preemptions tolerated before an update is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
lookup_en  in  1  fetch requests a prediction this cycle
lookup_index  in  INDEX_WIDTH  table index for the lookup
lookup_ready  out  1  lookup accepted this cycle
pred_valid  out  1  prediction available, one cycle after an accepted lookup
pred_taken  out  1  MSB of the looked-up counter
pred_count  out  COUNTER_WIDTH  looked-up counter value
upd_valid  in  1  resolved branch update offered
upd_index  in  INDEX_WIDTH  index of the resolved branch
upd_taken  in  1  actual branch outcome
upd_ready  out  1  FIFO not full
clear_req  in  1  pulse; start a full-table clear
busy  out  1  clear in progress
tbl_en  out  1  table port enable
tbl_we  out  1  table write enable
tbl_addr  out  INDEX_WIDTH  table address
tbl_wdata  out  COUNTER_WIDTH  table write data
tbl_rdata  in  COUNTER_WIDTH  table read data; synchronous, valid the cycle after a read

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO emptied, starve counter 0, clear pointer 0.
  - State = CLEAR, busy=1.
  - pred_valid=0, pred_taken=0, pred_count=0, tbl_en=0, tbl_we=0, upd_ready=0.
  - A reset mid-operation discards any in-flight RMW and pending updates.
- FSM states: CLEAR, IDLE, UPD_RD, UPD_WR.
- CLEAR:
  - Each cycle: tbl_en=1, tbl_we=1, tbl_addr=ptr, tbl_wdata=COUNTER_INIT, ptr++.
  - Goes to IDLE the cycle after ptr = 2**INDEX_WIDTH-1 is written, so a clear takes exactly 2**INDEX_WIDTH cycles.
  - Lookups are accepted with no table access: lookup_ready=1, and the next cycle pred_valid=1, pred_taken=0, pred_count=0.
  - upd_ready=0; upd_valid is ignored.
- clear_req in any state:
  - Enters CLEAR next cycle with ptr=0.
  - Flushes the FIFO and aborts any in-flight RMW.
  - clear_req during CLEAR restarts the clear at ptr=0.
- IDLE: if the FIFO is non-empty, pop the head into the RMW register and go to UPD_RD.
- UPD_RD: read tbl_addr=head index.
  - If lookup_en is high, the lookup takes the port instead; stay in UPD_RD and increment the starve counter.
  - Otherwise go to UPD_WR.
- UPD_WR:
  - New value = rdata+1 if taken, saturating at 2**COUNTER_WIDTH-1; rdata-1 if not taken, saturating at 0.
  - Latch the new value in the UPD_RD→UPD_WR transition cycle+1, when tbl_rdata is valid.
  - Write it, then go to IDLE, or straight to UPD_RD if the FIFO is non-empty (pop that cycle).
  - If lookup_en is high, the lookup preempts; the write is held and the starve counter increments.
- Starvation:
  - When the starve counter = STARVE_LIMIT, lookup_ready=0 for one cycle and the pending RMW step proceeds.
  - The counter clears on every completed RMW step.
- Lookup path: an accepted lookup drives tbl_en=1, tbl_we=0, tbl_addr=lookup_index. The next cycle: pred_valid=1, pred_count=tbl_rdata, pred_taken=MSB.
- FIFO:
  - Push when upd_valid && upd_ready; upd_ready = !full && state!=CLEAR.
  - A push and a pop in the same cycle are both legal, including when full.
  - Pointers wrap modulo depth; an extra MSB distinguishes full from empty.
- Same-index hazard: a lookup reading an index with a pending RMW returns the old table value (unless the option below is compiled in).

Optional Feature:
- Macro BP_UPD_BYPASS_EN.
- Defined: when an accepted lookup preempts UPD_WR and lookup_index equals the RMW index, pred_count/pred_taken return the pending new value instead of tbl_rdata.
- Undefined: no forwarding; the stale table value is returned.

Decomposition:
- Shared package holds:
  - State encoding constants (CLEAR/IDLE/UPD_RD/UPD_WR).
  - The saturating increment/decrement function.
  - The update record layout {index, taken}.
- One natural sub-module: bp_upd_fifo (synchronous FIFO, parameterised width/depth, full/empty flags).

Test Plan:
- Reset, then no stimulus → busy=1 for 64 cycles, 64 writes of 0 to addresses 0..63, then busy=0 and upd_ready=1.
- After clear, 3 taken updates to index 5, no lookups → entry 5 = 3 and stays 3 on a 4th taken update (saturation); a lookup of 5 returns pred_count=3, pred_taken=1.
- FIFO full (4 entries) with upd_valid held → upd_ready=0; pushes resume the cycle after the first pop; no update is lost (check final counters).
- lookup_en held high with 1 pending update → exactly 4 preemptions, then lookup_ready=0 for one cycle and the RMW progresses; the update completes within 10 cycles.
- clear_req mid-RMW with 2 entries queued → FIFO empties and the in-flight write is not performed; after 64 cycles every entry reads COUNTER_INIT.
- With BP_UPD_BYPASS_EN, entry 9 = 1, taken update, lookup of 9 preempting UPD_WR → pred_count=2; without the macro → pred_count=1.

Source files
------------

// File: rtl/bp_table_scheduler_pkg.sv
// Shared types and helpers for the pattern-history table scheduler:
// FSM encoding, prediction source select, update record layout, saturating step.
package bp_table_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_UPD_RD,
      ST_UPD_WR
   } sched_state_t;

   typedef enum logic [1:0] {
      PRED_ZERO,
      PRED_TABLE,
      PRED_BYPASS
   } pred_src_t;

   // Update record is packed as {index, taken}; taken occupies the LSB.
   localparam int unsigned UPD_TAKEN_BIT = 0;

   function automatic int unsigned upd_rec_width(input int unsigned index_width);
      return index_width + 1;
   endfunction

   function automatic logic [31:0] sat_step(input logic [31:0] cnt,
                                            input logic taken,
                                            input int unsigned width);
      logic [31:0] max_val;
      max_val = (32'd1 << width) - 32'd1;
      if (taken)
         return (cnt >= max_val) ? max_val : cnt + 32'd1;
      else
         return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
   endfunction

endpackage

// File: rtl/bp_table_scheduler_upd_fifo.sv
// Synchronous update FIFO with flush; extra pointer MSB separates full from empty.
module bp_upd_fifo #(
   parameter int unsigned WIDTH      = 7,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
   end

endmodule

// File: rtl/bp_table_scheduler.sv
// Pattern-history table port scheduler: lookups, buffered RMW updates, table clears.
// Optional BP_UPD_BYPASS_EN forwards a pending RMW value to a same-index lookup.
module bp_table_scheduler
   import bp_table_scheduler_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH     = 6,
   parameter int unsigned COUNTER_WIDTH   = 2,
   parameter int unsigned COUNTER_INIT    = 0,
   parameter int unsigned FIFO_ADDR_WIDTH = 2,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lookup_en,
   input  logic [INDEX_WIDTH-1:0]   lookup_index,
   output logic                     lookup_ready,
   output logic                     pred_valid,
   output logic                     pred_taken,
   output logic [COUNTER_WIDTH-1:0] pred_count,
   input  logic                     upd_valid,
   input  logic [INDEX_WIDTH-1:0]   upd_index,
   input  logic                     upd_taken,
   output logic                     upd_ready,
   input  logic                     clear_req,
   output logic                     busy,
   output logic                     tbl_en,
   output logic                     tbl_we,
   output logic [INDEX_WIDTH-1:0]   tbl_addr,
   output logic [COUNTER_WIDTH-1:0] tbl_wdata,
   input  logic [COUNTER_WIDTH-1:0] tbl_rdata
);

   localparam int unsigned REC_W    = upd_rec_width(INDEX_WIDTH);
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [COUNTER_WIDTH-1:0] INIT_VAL = COUNTER_WIDTH'(COUNTER_INIT);

   sched_state_t               state;
   pred_src_t                  pred_src;
   logic [INDEX_WIDTH-1:0]     clr_ptr;
   logic [INDEX_WIDTH-1:0]     rmw_index;
   logic                       rmw_taken;
   logic                       rd_fresh;
   logic [COUNTER_WIDTH-1:0]   new_val_q;
   logic [COUNTER_WIDTH-1:0]   new_val;
   logic [COUNTER_WIDTH-1:0]   bypass_q;
   logic [STARVE_W-1:0]        starve;
   logic                       pred_valid_q;
   logic                       starved;
   logic                       lookup_acc;
   logic                       fifo_push;
   logic                       fifo_pop;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [REC_W-1:0]           fifo_head;
   logic [INDEX_WIDTH-1:0]     head_index;
   logic                       head_taken;

   bp_upd_fifo #(
      .WIDTH      (REC_W),
      .ADDR_WIDTH (FIFO_ADDR_WIDTH)
   ) u_upd_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (clear_req),
      .push      (fifo_push),
      .push_data ({upd_index, upd_taken}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_index = fifo_head[REC_W-1 -: INDEX_WIDTH];
   assign head_taken = fifo_head[UPD_TAKEN_BIT];

   assign starved      = ((state == ST_UPD_RD) || (state == ST_UPD_WR)) &&
                         (starve == STARVE_W'(STARVE_LIMIT));
   assign lookup_ready = !rst && !starved;
   assign lookup_acc   = lookup_en && lookup_ready;
   assign upd_ready    = !rst && !fifo_full && (state != ST_CLEAR);
   assign fifo_push    = upd_valid && upd_ready;
   assign fifo_pop     = !rst && !clear_req && !fifo_empty &&
                         ((state == ST_IDLE) || ((state == ST_UPD_WR) && !lookup_acc));

   // Read data is only valid in the first UPD_WR cycle; later cycles use the latched copy.
   assign new_val = rd_fresh ?
                    COUNTER_WIDTH'(sat_step(32'(tbl_rdata), rmw_taken, COUNTER_WIDTH)) :
                    new_val_q;

   assign busy       = (state == ST_CLEAR);
   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_count[COUNTER_WIDTH-1];

   always_comb begin
      pred_count = '0;
      case (pred_src)
         PRED_TABLE:  pred_count = tbl_rdata;
         PRED_BYPASS: pred_count = bypass_q;
         default:     pred_count = '0;
      endcase
   end

   always_comb begin
      tbl_en    = 1'b0;
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = '0;
      if (!rst) begin
         if (state == ST_CLEAR) begin
            tbl_en    = 1'b1;
            tbl_we    = 1'b1;
            tbl_addr  = clr_ptr;
            tbl_wdata = INIT_VAL;
         end else if (lookup_acc) begin
            tbl_en   = 1'b1;
            tbl_addr = lookup_index;
         end else if (!clear_req) begin
            if (state == ST_UPD_RD) begin
               tbl_en   = 1'b1;
               tbl_addr = rmw_index;
            end else if (state == ST_UPD_WR) begin
               tbl_en    = 1'b1;
               tbl_we    = 1'b1;
               tbl_addr  = rmw_index;
               tbl_wdata = new_val;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_CLEAR;
         clr_ptr      <= '0;
         starve       <= '0;
         rd_fresh     <= 1'b0;
         rmw_index    <= '0;
         rmw_taken    <= 1'b0;
         new_val_q    <= '0;
         bypass_q     <= '0;
         pred_valid_q <= 1'b0;
         pred_src     <= PRED_ZERO;
      end else begin
         pred_valid_q <= lookup_acc;
         pred_src     <= (lookup_acc && (state != ST_CLEAR)) ? PRED_TABLE : PRED_ZERO;
`ifdef BP_UPD_BYPASS_EN
         if (lookup_acc && (state == ST_UPD_WR) && (lookup_index == rmw_index)) begin
            pred_src <= PRED_BYPASS;
            bypass_q <= new_val;
         end
`endif
         rd_fresh <= 1'b0;
         if (clear_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            starve  <= '0;
         end else begin
            case (state)
               ST_CLEAR: begin
                  clr_ptr <= clr_ptr + 1'b1;
                  if (clr_ptr == '1) state <= ST_IDLE;
               end
               ST_IDLE: begin
                  if (!fifo_empty) begin
                     rmw_index <= head_index;
                     rmw_taken <= head_taken;
                     state     <= ST_UPD_RD;
                  end
               end
               ST_UPD_RD: begin
                  if (lookup_acc) begin
                     starve <= starve + 1'b1;
                  end else begin
                     starve   <= '0;
                     rd_fresh <= 1'b1;
                     state    <= ST_UPD_WR;
                  end
               end
               ST_UPD_WR: begin
                  if (rd_fresh) new_val_q <= new_val;
                  if (lookup_acc) begin
                     starve <= starve + 1'b1;
                  end else begin
                     starve <= '0;
                     if (!fifo_empty) begin
                        rmw_index <= head_index;
                        rmw_taken <= head_taken;
                        state     <= ST_UPD_RD;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end
               default: state <= ST_CLEAR;
            endcase
         end
      end
   end

endmodule
